// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU.
// Holds the decoded operands and controls for the instruction in EX.
// Forwards MEM/WB results onto the ALU operands and picks the B operand.
// Flags load-use hazards so that upstream holds and EX takes a bubble.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [10:0]     id_ctrl,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_scr_a,
    output logic [XLEN-1:0] ex_scr_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      ex_alu_control,
    output logic [5:0]      ex_ctrl,
    output logic [4:0]      ex_rd_addr
);

    // Bit position of mem_read inside the 6-bit EX control field
    localparam int CTRL_MEM_READ = 1;

    logic            r_valid;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [3:0]      r_alu_ctl;
    logic            r_src_b_imm;
    logic [5:0]      r_ctrl;

    logic            w_load_use;
    logic            w_wb_hit_rs1;
    logic            w_wb_hit_rs2;
    logic            w_fwd_mem_a;
    logic            w_fwd_mem_b;
    logic            w_fwd_wb_a;
    logic            w_fwd_wb_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    // A load in EX whose rd is read by the instruction in ID cannot be
    // forwarded in time; a redirect makes the ID instruction irrelevant.
    assign w_load_use = id_valid && r_valid && r_ctrl[CTRL_MEM_READ]
                        && (r_rd_addr != 5'd0)
                        && ((id_rs1_addr == r_rd_addr) || (id_rs2_addr == r_rd_addr))
                        && !flush;

    // WB writes that target a stored source register; x0 is never written
    assign w_wb_hit_rs1 = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == r_rs1_addr);
    assign w_wb_hit_rs2 = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == r_rs2_addr);

    // Forwarding matches, disabled entirely in non-forwarding builds
    assign w_fwd_mem_a = FWD_EN && mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == r_rs1_addr);
    assign w_fwd_mem_b = FWD_EN && mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == r_rs2_addr);
    assign w_fwd_wb_a  = FWD_EN && w_wb_hit_rs1;
    assign w_fwd_wb_b  = FWD_EN && w_wb_hit_rs2;

    // EX register: reset, flush bubble, hold (with WB refresh), load-use bubble, or load from ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_ctl   <= '0;
            r_src_b_imm <= 1'b0;
            r_ctrl      <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_ctl   <= '0;
            r_src_b_imm <= 1'b0;
            r_ctrl      <= '0;
        end else if (stall) begin
            if (w_wb_hit_rs1) begin
                r_rs1_data <= wb_fwd_data;
            end
            if (w_wb_hit_rs2) begin
                r_rs2_data <= wb_fwd_data;
            end
        end else if (w_load_use || !id_valid) begin
            r_valid     <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_ctl   <= '0;
            r_src_b_imm <= 1'b0;
            r_ctrl      <= '0;
        end else begin
            r_valid     <= 1'b1;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_rd_addr   <= id_rd_addr;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_alu_ctl   <= id_ctrl[10:7];
            r_src_b_imm <= id_ctrl[6];
            r_ctrl      <= id_ctrl[5:0];
        end
    end

    // Operand selection: MEM result is newest, then WB, then the stored value
    always_comb begin
        w_op_a = r_rs1_data;
        w_op_b = r_rs2_data;
        if (w_fwd_mem_a) begin
            w_op_a = mem_fwd_data;
        end else if (w_fwd_wb_a) begin
            w_op_a = wb_fwd_data;
        end
        if (w_fwd_mem_b) begin
            w_op_b = mem_fwd_data;
        end else if (w_fwd_wb_b) begin
            w_op_b = wb_fwd_data;
        end
    end

    assign hazard_stall   = w_load_use;
    assign ex_valid       = r_valid;
    assign ex_scr_a       = w_op_a;
    assign ex_scr_b       = r_src_b_imm ? r_imm : w_op_b;
    assign ex_store_data  = w_op_b;
    assign ex_alu_control = r_alu_ctl;
    assign ex_ctrl        = r_ctrl;
    assign ex_rd_addr     = r_rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios followed by
// randomized traffic, checked against an instruction-level model of EX.
module tb_id_ex_stage;

    localparam logic [10:0] CTRL_ADD = 11'h004;
    localparam logic [10:0] CTRL_LW  = 11'h046;
    localparam logic [10:0] CTRL_SW  = 11'h041;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        idValid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [10:0] ctrl;
        logic        memWe;
        logic [4:0]  memRd;
        logic [31:0] memData;
        logic        wbWe;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
    } stim_t;

    // The instruction currently sitting in EX, as the model sees it
    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        srcImm;
        logic [5:0]  ctrl;
    } exModel_t;

    typedef struct {
        logic        hazard;
        logic        valid;
        logic [31:0] scrA;
        logic [31:0] scrB;
        logic [31:0] store;
        logic [3:0]  alu;
        logic [5:0]  ctrl;
        logic [4:0]  rd;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [10:0] id_ctrl;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        hazard_stall;
    logic        ex_valid;
    logic [31:0] ex_scr_a;
    logic [31:0] ex_scr_b;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [5:0]  ex_ctrl;
    logic [4:0]  ex_rd_addr;

    int checkCount = 0;
    int errorCount = 0;
    expect_t expQueue[$];
    exModel_t model;

    id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_scr_a(ex_scr_a), .ex_scr_b(ex_scr_b),
        .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control), .ex_ctrl(ex_ctrl),
        .ex_rd_addr(ex_rd_addr)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exModel_t emptyEx();
        exModel_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t instrStim(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [31:0] imm, input logic [10:0] ctrl);
        stim_t s;
        s = idleStim();
        s.idValid = 1'b1;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.d1 = d1; s.d2 = d2; s.imm = imm; s.ctrl = ctrl;
        return s;
    endfunction

    // Newest architectural value of a register as seen from EX this cycle
    function automatic logic [31:0] latestValue(input logic [4:0] addr, input logic [31:0] stored, input stim_t s);
        if (addr == 5'd0) return stored;
        if (s.memWe && s.memRd == addr) return s.memData;
        if (s.wbWe && s.wbRd == addr) return s.wbData;
        return stored;
    endfunction

    task automatic driveInputs(input stim_t s);
        stall = s.stall; flush = s.flush; id_valid = s.idValid;
        id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; id_rd_addr = s.rd;
        id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm; id_ctrl = s.ctrl;
        mem_fwd_we = s.memWe; mem_fwd_rd = s.memRd; mem_fwd_data = s.memData;
        wb_fwd_we = s.wbWe; wb_fwd_rd = s.wbRd; wb_fwd_data = s.wbData;
    endtask

    // One cycle: drive, predict this cycle's outputs, then advance the model across the edge
    task automatic applyStimulus(input stim_t s);
        expect_t e;
        logic loadUse;
        driveInputs(s);
        #1;
        loadUse = !s.flush && s.idValid && model.valid && model.ctrl[1] && (model.rd != 5'd0)
                  && ((s.rs1 == model.rd) || (s.rs2 == model.rd));
        e.hazard = loadUse;
        e.valid  = model.valid;
        e.scrA   = latestValue(model.rs1, model.d1, s);
        e.store  = latestValue(model.rs2, model.d2, s);
        e.scrB   = model.srcImm ? model.imm : e.store;
        e.alu    = model.alu;
        e.ctrl   = model.ctrl;
        e.rd     = model.rd;
        expQueue.push_back(e);
        @(posedge clk);
        if (s.flush) begin
            model = emptyEx();
        end else if (s.stall) begin
            if (s.wbWe && s.wbRd != 5'd0 && s.wbRd == model.rs1) model.d1 = s.wbData;
            if (s.wbWe && s.wbRd != 5'd0 && s.wbRd == model.rs2) model.d2 = s.wbData;
        end else if (loadUse || !s.idValid) begin
            model = emptyEx();
        end else begin
            model.valid  = 1'b1;
            model.rs1    = s.rs1; model.rs2 = s.rs2; model.rd = s.rd;
            model.d1     = s.d1; model.d2 = s.d2; model.imm = s.imm;
            model.alu    = s.ctrl[10:7];
            model.srcImm = s.ctrl[6];
            model.ctrl   = s.ctrl[5:0];
        end
        #1;
    endtask

    // Monitor: compares presented outputs against the oldest pending prediction
    always @(negedge clk) begin
        if (rst_n && expQueue.size() > 0) begin
            expect_t e;
            e = expQueue.pop_front();
            checkOutput("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hazard});
            checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            checkOutput("ex_ctrl", {26'd0, ex_ctrl}, {26'd0, e.ctrl});
            checkOutput("ex_alu_control", {28'd0, ex_alu_control}, {28'd0, e.alu});
            checkOutput("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
            if (e.valid) begin
                checkOutput("ex_scr_a", ex_scr_a, e.scrA);
                checkOutput("ex_scr_b", ex_scr_b, e.scrB);
                checkOutput("ex_store_data", ex_store_data, e.store);
            end
        end
    end

    initial begin
        stim_t s;
        model = emptyEx();
        rst_n = 1'b0;
        driveInputs(idleStim());
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("reset_ex_ctrl", {26'd0, ex_ctrl}, 32'd0);
        checkOutput("reset_scr_a", ex_scr_a, 32'd0);
        rst_n = 1'b1;

        // Back-to-back dependency resolved from MEM
        applyStimulus(instrStim(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, CTRL_ADD));
        applyStimulus(instrStim(5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, CTRL_ADD));
        s = idleStim();
        s.memWe = 1'b1; s.memRd = 5'd3; s.memData = 32'd12;
        driveInputs(s);
        #1;
        checkOutput("mem_fwd_scr_a", ex_scr_a, 32'd12);
        checkOutput("mem_fwd_scr_b", ex_scr_b, 32'd12);
        applyStimulus(s);

        // MEM beats WB; x0 never forwarded
        applyStimulus(instrStim(5'd3, 5'd0, 5'd7, 32'h55, 32'd0, 32'd0, CTRL_ADD));
        s = idleStim();
        s.memWe = 1'b1; s.memRd = 5'd3; s.memData = 32'hAA;
        s.wbWe = 1'b1; s.wbRd = 5'd3; s.wbData = 32'hBB;
        driveInputs(s);
        #1;
        checkOutput("mem_over_wb", ex_scr_a, 32'hAA);
        s.memRd = 5'd0; s.wbWe = 1'b0;
        driveInputs(s);
        #1;
        checkOutput("x0_no_fwd", ex_scr_a, 32'h55);
        applyStimulus(s);

        // Load-use: one bubble, then the dependent instruction picks up WB
        applyStimulus(instrStim(5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 32'd4, CTRL_LW));
        s = instrStim(5'd5, 5'd1, 5'd6, 32'd0, 32'd9, 32'd0, CTRL_ADD);
        driveInputs(s);
        #1;
        checkOutput("load_use_hazard", {31'd0, hazard_stall}, 32'd1);
        applyStimulus(s);
        checkOutput("load_use_bubble", {31'd0, ex_valid}, 32'd0);
        checkOutput("load_use_one_bubble", {31'd0, hazard_stall}, 32'd0);
        applyStimulus(s);
        s = idleStim();
        s.wbWe = 1'b1; s.wbRd = 5'd5; s.wbData = 32'h77;
        driveInputs(s);
        #1;
        checkOutput("load_use_wb_fwd", ex_scr_a, 32'h77);
        applyStimulus(s);

        // Hold with a WB retirement during the hold; SW keeps imm on B
        applyStimulus(instrStim(5'd1, 5'd6, 5'd0, 32'd0, 32'h1111, 32'd8, CTRL_SW));
        s = instrStim(5'd2, 5'd2, 5'd9, 32'd1, 32'd1, 32'd0, CTRL_ADD);
        s.stall = 1'b1;
        applyStimulus(s);
        s.wbWe = 1'b1; s.wbRd = 5'd6; s.wbData = 32'h1234;
        applyStimulus(s);
        s.wbWe = 1'b0;
        applyStimulus(s);
        checkOutput("hold_refresh_store", ex_store_data, 32'h1234);
        checkOutput("sw_scr_b_imm", ex_scr_b, 32'd8);
        s.stall = 1'b0;
        applyStimulus(s);

        // Flush wins over stall
        applyStimulus(instrStim(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, CTRL_ADD));
        s = instrStim(5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, CTRL_ADD);
        s.stall = 1'b1; s.flush = 1'b1;
        applyStimulus(s);
        checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("flush_ctrl", {26'd0, ex_ctrl}, 32'd0);

        // Asynchronous reset in the middle of a valid instruction
        applyStimulus(instrStim(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd3, CTRL_LW));
        checkOutput("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("async_reset_ctrl", {26'd0, ex_ctrl}, 32'd0);
        checkOutput("async_reset_alu", {28'd0, ex_alu_control}, 32'd0);
        checkOutput("async_reset_rd", {27'd0, ex_rd_addr}, 32'd0);
        checkOutput("async_reset_scr_b", ex_scr_b, 32'd0);
        model = emptyEx();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic on a small register window to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            s = idleStim();
            s.stall   = ($urandom_range(0, 99) < 20);
            s.flush   = ($urandom_range(0, 99) < 8);
            s.idValid = ($urandom_range(0, 99) < 85);
            s.rs1     = 5'($urandom_range(0, 7));
            s.rs2     = 5'($urandom_range(0, 7));
            s.rd      = 5'($urandom_range(0, 7));
            s.d1      = $urandom;
            s.d2      = $urandom;
            s.imm     = $urandom;
            s.ctrl    = 11'($urandom);
            s.memWe   = 1'($urandom);
            s.memRd   = 5'($urandom_range(0, 7));
            s.memData = $urandom;
            s.wbWe    = 1'($urandom);
            s.wbRd    = 5'($urandom_range(0, 7));
            s.wbData  = $urandom;
            applyStimulus(s);
        end

        for (int w = 0; w < 5 && expQueue.size() > 0; w++) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", expQueue.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
